data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Word-addressed data memory that answers one cache request at a time with a
// fixed latency. A request is captured while IDLE and completes LATENCY cycles
// later with a single-cycle m_ready pulse. DONE is always followed by one IDLE
// turnaround cycle.
//
// Handshake: m_strobe is request-valid and is sampled only in IDLE. The
// address, write data and direction are latched at the capture edge. Once
// captured, a request always completes, even if m_strobe drops. m_ready is the
// completion strobe and is high for exactly one cycle (DONE). There is no
// backpressure on m_ready.
//
// Optional feature: define DMEM_ERR_EN to enable range checking of the upper
// address bits. This adds the m_err port, suppresses out-of-range writes and
// returns 32'hDEADBEEF for out-of-range reads. Without the macro, the upper
// address bits alias silently.
//
// Parameters
//   A_WIDTH  address width in bits
//   M_INDEX  word-index width; the array holds 2**M_INDEX 32-bit words
//   LATENCY  number of cycles from the capture edge to m_ready (1..15)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   m_a          request byte address (bits [1:0] ignored)
//   m_din        write data (full merged 32-bit word)
//   m_strobe     request valid
//   m_rw         0 = read, 1 = write
//   m_dout       read data; holds until the next read completes
//   m_ready      one-cycle completion pulse (registered)
//   m_err        (DMEM_ERR_EN only) range error, valid with m_ready
//   dbg_state_o  FSM state for checkers: 0 = IDLE, 1 = BUSY, 2 = DONE
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int A_WIDTH = 32,
  parameter int M_INDEX = 10,
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  input  logic               m_strobe,
  input  logic               m_rw,
  output logic [31:0]        m_dout,
  output logic               m_ready,
`ifdef DMEM_ERR_EN
  output logic               m_err,
`endif
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam int         DEPTH  = 1 << M_INDEX;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [M_INDEX-1:0]   idx_q;
  logic [31:0]          din_q;
  logic                 rw_q;
  logic [31:0]          dout_q;
  logic                 ready_q;
  logic [31:0]          mem_q [0:DEPTH-1];

  logic                 capture;
  logic                 enter_done;
  logic [M_INDEX-1:0]   eff_idx;
  logic                 eff_rw;
  logic                 eff_err;
  logic                 err_lat;

  // The byte offset never selects anything; only whole words are stored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^m_a[1:0];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m_strobe) begin
          capture = 1'b1;
          cnt_d   = LAT_M1;
          state_d = (LATENCY > 1) ? BUSY : DONE;
        end
      end
      BUSY: begin
        // The counter reaching zero at this edge ends the wait.
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign enter_done = (state_d == DONE) && (state_q != DONE);

  // With LATENCY=1, capture and entry into DONE happen on the same edge, so the
  // read must use the live request rather than the not-yet-latched copy.
  assign eff_idx = capture ? m_a[M_INDEX+1:2] : idx_q;
  assign eff_rw  = capture ? m_rw : rw_q;

`ifdef DMEM_ERR_EN
  logic err_q;
  logic err_out_q;

  assign eff_err = capture ? (|m_a[A_WIDTH-1:M_INDEX+2]) : err_q;
  assign err_lat = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      if (capture) err_q <= |m_a[A_WIDTH-1:M_INDEX+2];
      err_out_q <= enter_done && eff_err;
    end
  end

  assign m_err = err_out_q;
`else
  logic unused_addr_msbs;
  assign unused_addr_msbs = ^m_a[A_WIDTH-1:M_INDEX+2];
  assign eff_err = 1'b0;
  assign err_lat = 1'b0;
`endif

  // State, request latch and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      din_q   <= 32'h0;
      rw_q    <= 1'b0;
      dout_q  <= 32'h0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= enter_done;
      if (capture) begin
        idx_q <= m_a[M_INDEX+1:2];
        din_q <= m_din;
        rw_q  <= m_rw;
      end
      if (enter_done && !eff_rw) begin
        dout_q <= eff_err ? 32'hDEADBEEF : mem_q[eff_idx];
      end
    end
  end

  // The array has no reset. The write commits at the edge that ends DONE, so a
  // reset during BUSY or DONE drops it.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == DONE) && rw_q && !err_lat) begin
      mem_q[idx_q] <= din_q;
    end
  end

  assign m_dout      = dout_q;
  assign m_ready     = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// This self-checking bench uses a cycle-count reference model. The model
// tracks the edge at which each request is captured. From that edge it derives:
//   - the cycle in which completion is due (capture edge + LATENCY - 1),
//   - the edge that ends DONE, when a write commits, and
//   - the first edge at which a new capture is allowed.
//
// Expected read data is taken from a plain array at capture time and queued.
// With a single outstanding request, nothing can change that word before
// completion.
//
// Every negedge, a compare process checks m_ready, m_dout, the debug state
// and, when enabled, m_err. Directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int A_WIDTH = 32;
  localparam int M_INDEX = 10;
  localparam int LATENCY = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [31:0] m_a      = 32'h0;
  logic [31:0] m_din    = 32'h0;
  logic        m_strobe = 1'b0;
  logic        m_rw     = 1'b0;
  logic [31:0] m_dout;
  logic        m_ready;
  logic [1:0]  dbg_state;
`ifdef DMEM_ERR_EN
  logic        m_err;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(
    .A_WIDTH(A_WIDTH),
    .M_INDEX(M_INDEX),
    .LATENCY(LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_a        (m_a),
    .m_din      (m_din),
    .m_strobe   (m_strobe),
    .m_rw       (m_rw),
    .m_dout     (m_dout),
    .m_ready    (m_ready),
`ifdef DMEM_ERR_EN
    .m_err      (m_err),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl_mem [0:1023];
  logic [31:0] exp_q[$];
  int          edge_cnt  = 0;
  int          next_cap  = 0;
  int          done_edge = 0;
  bit          have_req  = 1'b0;
  int          req_idx   = 0;
  logic [31:0] req_din   = 32'h0;
  bit          req_rw    = 1'b0;
  bit          req_err   = 1'b0;
  logic [31:0] exp_dout  = 32'h0;
  bit          chk_en    = 1'b0;

  function automatic bit addr_err(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return |a[31:12];
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      have_req = 1'b0;
      exp_q.delete();
      exp_dout = 32'h0;
      next_cap = edge_cnt + 1;
    end else if (have_req && edge_cnt == done_edge + 1) begin
      if (req_rw && !req_err) mdl_mem[req_idx] = req_din;
      have_req = 1'b0;
      next_cap = edge_cnt + 1;
    end else if (!have_req && edge_cnt >= next_cap && m_strobe) begin
      have_req  = 1'b1;
      done_edge = edge_cnt + LATENCY - 1;
      req_idx   = int'(m_a[11:2]);
      req_din   = m_din;
      req_rw    = m_rw;
      req_err   = addr_err(m_a);
      if (!m_rw) exp_q.push_back(req_err ? 32'hDEADBEEF : mdl_mem[req_idx]);
    end
    edge_cnt++;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit         exp_rdy;
    logic [1:0] exp_st;
    if (chk_en) begin
      exp_rdy = have_req && (done_edge == edge_cnt - 1);
      exp_st  = !have_req ? 2'd0 : (exp_rdy ? 2'd2 : 2'd1);
      if (exp_rdy && !req_rw) begin
        if (exp_q.size() == 0) chk("exp_q_depth", 0, 1);
        else exp_dout = exp_q.pop_front();
      end
      chk("m_ready", {31'b0, m_ready}, {31'b0, exp_rdy});
      chk("m_dout", m_dout, exp_dout);
      chk("dbg_state", {30'b0, dbg_state}, {30'b0, exp_st});
`ifdef DMEM_ERR_EN
      chk("m_err", {31'b0, m_err}, {31'b0, exp_rdy && req_err});
`endif
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. Presents the request for exactly one
  // edge, then scrambles the inputs and waits for completion (bounded).
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input bit rw,
                        output int lat, output logic [31:0] dout);
    m_a = a; m_din = d; m_rw = rw; m_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_strobe = 1'b0;
    m_a      = $urandom;
    m_din    = $urandom;
    m_rw     = 1'($urandom_range(0, 1));
    lat = 0;
    while (!m_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    dout = m_dout;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    logic [31:0] dv;
    logic [9:0]  rdy_mask;
    bit          rdy_seen;

    // A strobe held during reset must not be captured.
    rst = 1'b1; m_strobe = 1'b1; m_rw = 1'b1; m_a = 32'h40; m_din = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_ready", {31'b0, m_ready}, 32'h0);
    chk("reset_dout", m_dout, 32'h0);
    m_strobe = 1'b0;
    rst      = 1'b0;
    @(negedge clk);

    // Give every word the random phase can touch a known value.
    for (int i = 0; i < 128; i++) do_req(32'(i << 2), $urandom, 1'b1, lat, dv);

    // Write then read back 0x40
    do_req(32'h40, 32'h12345678, 1'b1, lat, dv);
    chk("wr40_latency", 32'(lat), 32'd2);
    do_req(32'h40, 32'h0, 1'b0, lat, dv);
    chk("rd40_latency", 32'(lat), 32'd2);
    chk("rd40_data", dv, 32'h12345678);

    // Byte offset is ignored
    do_req(32'h40, 32'hCAFEF00D, 1'b1, lat, dv);
    do_req(32'h43, 32'h0, 1'b0, lat, dv);
    chk("rd43_data", dv, 32'hCAFEF00D);

    // Strobe drop and address change after capture
    do_req(32'h80, 32'hAAAA5555, 1'b1, lat, dv);
    chk("wr80_latency", 32'(lat), 32'd2);
    do_req(32'h80, 32'h0, 1'b0, lat, dv);
    chk("rd80_data", dv, 32'hAAAA5555);

    // Back-to-back reads with strobe held high
    do_req(32'h0, 32'h0000_1111, 1'b1, lat, dv);
    do_req(32'h4, 32'h2222_0000, 1'b1, lat, dv);
    rdy_mask = '0;
    m_a = 32'h0; m_rw = 1'b0; m_strobe = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) m_a = 32'h4;
      if (k == 4) m_strobe = 1'b0;
      rdy_mask[k] = m_ready;
      if (k == 2) chk("b2b_rd0_data", m_dout, 32'h0000_1111);
      if (k == 6) chk("b2b_rd4_data", m_dout, 32'h2222_0000);
    end
    chk("b2b_ready_pattern", {22'b0, rdy_mask}, {22'b0, 10'b00_0100_0100});

    // Reset in the middle of a write discards it
    do_req(32'h100, 32'h0, 1'b1, lat, dv);
    m_a = 32'h100; m_din = 32'h1; m_rw = 1'b1; m_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_strobe = 1'b0;
    rdy_seen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_ready) rdy_seen = 1'b1;
    end
    chk("rst_abort_no_ready", {31'b0, rdy_seen}, 32'h0);
    chk("rst_abort_dout", m_dout, 32'h0);
    do_req(32'h100, 32'h0, 1'b0, lat, dv);
    chk("rst_abort_mem", dv, 32'h0);

`ifdef DMEM_ERR_EN
    do_req(32'h0010_0000, 32'h0, 1'b0, lat, dv);
    chk("err_rd_data", dv, 32'hDEADBEEF);
    do_req(32'h0010_0000, 32'h5A5A_5A5A, 1'b1, lat, dv);
    do_req(32'h0, 32'h0, 1'b0, lat, dv);
    chk("err_wr_suppressed", dv, 32'h0000_1111);
`endif

    // Randomized traffic over the pre-written words, with aliasing upper bits
    repeat (200) begin
      logic [31:0] ra;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 127)) << 2)
         | 32'($urandom_range(0, 3));
      do_req(ra, $urandom, 1'($urandom_range(0, 1)), lat, dv);
      chk("rand_latency", 32'(lat), 32'd2);
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
